// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: pulls operand A, operand B and opcode from the RX FIFO,
// presents them to the combinational ALU, latches the result and pushes it to
// the TX FIFO. Partial frames that stall longer than TIMEOUT_CYCLES are
// discarded so the host can resynchronise.
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int NB_TIMEOUT     = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_read_uart,
    input  logic               i_tx_full,
    output logic               o_write_uart,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_frame_error,
    output logic [7:0]         o_frame_cnt
);

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_EXEC,
        ST_SEND
    } state_t;

    // TIMEOUT_CYCLES == 0 disables the timeout; the counter then stays at 0.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [NB_TIMEOUT-1:0] TO_LAST =
        NB_TIMEOUT'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NB_OP-1:0]     alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 frame_error_q, frame_error_d;
    logic [NB_TIMEOUT-1:0] to_cnt_q, to_cnt_d;
    logic                 read_s, write_s, timeout_fire;

    // Next-state, datapath capture, timeout counting and FIFO strobes.
    // A firing timeout takes priority over a byte arriving in the same cycle:
    // that byte stays in the FIFO and becomes operand A of the next frame.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        tx_data_d     = tx_data_q;
        frame_cnt_d   = frame_cnt_q;
        frame_error_d = 1'b0;
        to_cnt_d      = '0;
        read_s        = 1'b0;
        write_s       = 1'b0;
        timeout_fire  = TO_EN && ((state_q == ST_GET_B) || (state_q == ST_GET_OP))
                        && (to_cnt_q == TO_LAST);
        case (state_q)
            ST_GET_A: begin
                if (!i_rx_empty) begin
                    read_s  = 1'b1;
                    alu_a_d = i_rx_data;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B, ST_GET_OP: begin
                if (timeout_fire) begin
                    frame_error_d = 1'b1;
                    state_d       = ST_GET_A;
                end else if (!i_rx_empty) begin
                    read_s = 1'b1;
                    if (state_q == ST_GET_B) begin
                        alu_b_d = i_rx_data;
                        state_d = ST_GET_OP;
                    end else begin
                        alu_op_d = i_rx_data[NB_OP-1:0];
                        state_d  = ST_EXEC;
                    end
                end else begin
                    to_cnt_d = TO_EN ? to_cnt_q + 1'b1 : '0;
                end
            end
            ST_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (!i_tx_full) begin
                    write_s     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = ST_GET_A;
                end
            end
            default: state_d = ST_GET_A;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_GET_A;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tx_data_q     <= '0;
            frame_cnt_q   <= '0;
            frame_error_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            tx_data_q     <= tx_data_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_error_q <= frame_error_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign o_read_uart   = read_s & ~i_reset;
    assign o_write_uart  = write_s & ~i_reset;
    assign o_busy        = ((state_q == ST_EXEC) || (state_q == ST_SEND)) & ~i_reset;
    assign o_tx_data     = tx_data_q;
    assign o_alu_a       = alu_a_q;
    assign o_alu_b       = alu_b_q;
    assign o_alu_op      = alu_op_q;
    assign o_frame_error = frame_error_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Frame sequencer between the UART front end (RX/TX FIFOs) and the combinational ALU. It pulls three bytes from the RX FIFO in order: operand A, operand B, opcode. It presents them to the ALU on registered outputs, captures the result, and pushes one result byte into the TX FIFO. A per-frame inactivity timeout discards stalled partial frames so the host can resynchronise.

## Interface
Parameters:
- NB_DATA, 8, byte/operand width
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed inside a partial frame; 0 disables the timeout
- NB_TIMEOUT, 20, timeout counter width; must hold TIMEOUT_CYCLES-1

Ports:
- i_clk  in  1  system clock; single clock domain
- i_reset  in  1  synchronous, active-high reset
- i_rx_empty  in  1  RX FIFO empty flag
- i_rx_data  in  NB_DATA  RX FIFO head word (first-word-fall-through)
- o_read_uart  out  1  RX FIFO pop strobe
- i_tx_full  in  1  TX FIFO full flag
- o_write_uart  out  1  TX FIFO push strobe
- o_tx_data  out  NB_DATA  result byte to TX FIFO
- o_alu_a  out  NB_DATA  registered operand A
- o_alu_b  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- i_alu_result  in  NB_DATA  combinational ALU result
- o_busy  out  1  high in EXEC and SEND
- o_frame_error  out  1  one-cycle pulse on timeout discard
- o_frame_cnt  out  8  completed frames, modulo 256

## Operation
- FSM states: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- GET_x with i_rx_empty=0:
  - o_read_uart=1 for that cycle.
  - i_rx_data is captured into the matching register (o_alu_a / o_alu_b / o_alu_op) at the same edge.
  - Transitions: GET_A→GET_B→GET_OP→EXEC.
- GET_x with i_rx_empty=1: hold state; o_read_uart=0.
- EXEC, exactly one cycle:
  - i_alu_result (driven from the registered operands) is latched into o_tx_data.
  - Transition to SEND.
- SEND:
  - o_write_uart = ~i_tx_full.
  - On a write cycle: o_frame_cnt increments (wraps 255→0) and the FSM goes to GET_A.
  - While i_tx_full=1: hold, o_tx_data stable, no RX reads.
- o_read_uart and o_write_uart are combinational from state and flags, gated by ~i_reset. Both are never high in the same cycle.
- Timeout:
  - The counter runs only in GET_B and GET_OP.
  - It clears on every accepted byte and on every entry to GET_A.
  - It increments each cycle while the RX FIFO is empty.
  - When it reaches TIMEOUT_CYCLES-1 with the RX FIFO still empty: go to GET_A, pulse o_frame_error for 1 cycle (registered), leave o_frame_cnt unchanged.
  - o_alu_a/b/op keep their stale values after a discard.
- A byte arriving in the same cycle the timeout fires is not read. It remains in the FIFO and becomes operand A of the next frame.
- With TIMEOUT_CYCLES=0 the counter is held at 0 and never fires.
- Reset values: o_read_uart 0, o_write_uart 0, o_tx_data 0, o_alu_a 0, o_alu_b 0, o_alu_op 0, o_busy 0, o_frame_error 0, o_frame_cnt 0, timeout counter 0. Reset mid-frame abandons all partial state; no write is issued.

## Timing
- Byte acceptance: 1 byte per cycle maximum. With a pre-filled RX FIFO, the three reads happen on consecutive cycles.
- Operand-to-result: the opcode is captured at edge N. EXEC occupies cycle N+1. o_tx_data is valid and o_write_uart can assert from cycle N+2.
- Minimum frame period: 5 cycles (3 read, 1 EXEC, 1 SEND) with a non-full TX FIFO.
- o_busy tracks state combinationally: high in EXEC and SEND only.
- o_frame_error rises the cycle after the timeout edge and lasts exactly 1 cycle.
- o_frame_cnt updates at the edge where o_write_uart=1.

## Test plan
- Single frame:
  - Stimulus: RX delivers 0x05, 0x03, 0x20; ALU model 0x20=ADD.
  - Required: o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20; exactly one o_write_uart with o_tx_data=0x08; o_frame_cnt=1.
- Back-to-back:
  - Stimulus: 6 bytes preloaded (0x0A,0x04,0x22 then 0xF0,0x0F,0x24; model SUB/AND).
  - Required: reads on cycles 0,1,2 then 5,6,7; writes 0x06 then 0x00; 10-cycle total.
- TX backpressure:
  - Stimulus: i_tx_full=1 for 20 cycles after EXEC.
  - Required: o_write_uart low, o_tx_data held, no o_read_uart; the write occurs the first cycle i_tx_full=0.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: send 0x11 only, then idle.
  - Required: o_frame_error pulses once. A following clean frame 0x01,0x02,ADD yields 0x03, and 0x11 is not used.
- Reset mid-frame:
  - Stimulus: assert i_reset after operand B is read.
  - Required: all outputs return to reset values, no TX write occurs, and the next three bytes form a fresh frame.
- Counter wrap:
  - Stimulus: 257 frames.
  - Required: o_frame_cnt reads 0 after frame 256 and 1 after frame 257.
